// File: rtl/gnn_s2_pkg.sv
// ============================================================================
// Module   : gnn_s2_pkg
// Brief    : Shared constants and FSM state type for the S2 tile scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gnn_s2_pkg;

  localparam int FEAT_W      = 12;
  localparam int CHUNK_LOG2  = 5;
  localparam int ALL_FEATURE = 3703;
  localparam int NUM_CORE    = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage : gnn_s2_pkg

`default_nettype wire

// File: rtl/s2_core_split.sv
// ============================================================================
// Module   : s2_core_split
// Brief    : Combinational split of the remaining feature range into one round
//            of cores: active core count, tail length and final-round flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module s2_core_split
  import gnn_s2_pkg::*;
#(
  parameter int FEAT_W_P      = FEAT_W,
  parameter int ALL_FEATURE_P = ALL_FEATURE,
  parameter int NUM_CORE_P    = NUM_CORE,
  parameter int CHUNK_LOG2_P  = CHUNK_LOG2
) (
  input  logic [FEAT_W_P:0]                  cur_id,
  output logic [$clog2(NUM_CORE_P+1)-1:0]    cores,
  output logic [CHUNK_LOG2_P:0]              last_len,
  output logic                               is_last
);

  localparam int W  = FEAT_W_P + 1;
  localparam int CW = $clog2(NUM_CORE_P + 1);
  localparam int LW = CHUNK_LOG2_P + 1;

  localparam logic [W-1:0] c_all      = W'(ALL_FEATURE_P);
  localparam logic [W-1:0] c_chunk    = W'(1 << CHUNK_LOG2_P);
  localparam logic [W-1:0] c_chunk_m1 = W'((1 << CHUNK_LOG2_P) - 1);
  localparam logic [W-1:0] c_ncore    = W'(NUM_CORE_P);
  localparam logic [W-1:0] c_round    = W'(NUM_CORE_P << CHUNK_LOG2_P);

  logic [W-1:0] w_rem;
  logic [W-1:0] w_ceil;
  logic [W-1:0] w_cores;
  logic [W-1:0] w_prev;
  logic [W-1:0] w_tail;

  // True ceiling: adding CHUNK-1 before the shift never over-counts an exact multiple.
  assign w_rem   = c_all - cur_id;
  assign w_ceil  = (w_rem + c_chunk_m1) >> CHUNK_LOG2_P;
  assign w_cores = (w_ceil > c_ncore) ? c_ncore : w_ceil;
  assign w_prev  = (w_cores - W'(1)) << CHUNK_LOG2_P;
  assign w_tail  = w_rem - w_prev;

  assign cores    = w_cores[CW-1:0];
  assign last_len = (w_tail > c_chunk) ? LW'(1 << CHUNK_LOG2_P) : w_tail[LW-1:0];
  assign is_last  = (w_rem <= c_round);

endmodule : s2_core_split

`default_nettype wire

// File: rtl/s2_tile_scheduler.sv
// ============================================================================
// Module   : s2_tile_scheduler
// Brief    : Walks the feature range from start_id in rounds of NUM_CORE x CHUNK
//            and emits one tile descriptor per round over valid/ready.
//            Optional macro S2_SCHED_PERF_EN adds tile/stall perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module s2_tile_scheduler
  import gnn_s2_pkg::*;
#(
  parameter int FEAT_W_P      = FEAT_W,
  parameter int ALL_FEATURE_P = ALL_FEATURE,
  parameter int NUM_CORE_P    = NUM_CORE,
  parameter int CHUNK_LOG2_P  = CHUNK_LOG2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [FEAT_W_P-1:0]              start_id,
  output logic                             tile_valid,
  input  logic                             tile_ready,
  output logic [FEAT_W_P-1:0]              tile_base_id,
  output logic [$clog2(NUM_CORE_P+1)-1:0]  tile_core_cnt,
  output logic [CHUNK_LOG2_P:0]            tile_last_len,
  output logic                             tile_full,
  output logic                             tile_last,
  output logic                             busy,
  output logic                             done,
  output logic                             err
`ifdef S2_SCHED_PERF_EN
  ,
  output logic [15:0]                      perf_tiles,
  output logic [15:0]                      perf_stall
`endif
);

  localparam int W  = FEAT_W_P + 1;
  localparam int CW = $clog2(NUM_CORE_P + 1);
  localparam int LW = CHUNK_LOG2_P + 1;

  localparam logic [W-1:0]  c_all   = W'(ALL_FEATURE_P);
  localparam logic [W-1:0]  c_round = W'(NUM_CORE_P << CHUNK_LOG2_P);
  localparam logic [CW-1:0] c_ncore = CW'(NUM_CORE_P);

  state_t          r_state;
  logic [W-1:0]    r_cur_id;

  logic [CW-1:0]   w_cores;
  logic [LW-1:0]   w_last_len;
  logic            w_is_last;
  logic            w_start_ok;
  logic            w_bad_id;
  logic            w_hs;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_bad_id   = ({1'b0, start_id} >= c_all);
  assign w_hs       = tile_valid && tile_ready;

  s2_core_split #(
    .FEAT_W_P      (FEAT_W_P),
    .ALL_FEATURE_P (ALL_FEATURE_P),
    .NUM_CORE_P    (NUM_CORE_P),
    .CHUNK_LOG2_P  (CHUNK_LOG2_P)
  ) u_core_split (
    .cur_id   (r_cur_id),
    .cores    (w_cores),
    .last_len (w_last_len),
    .is_last  (w_is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cur_id      <= '0;
      tile_valid    <= 1'b0;
      tile_base_id  <= '0;
      tile_core_cnt <= '0;
      tile_last_len <= '0;
      tile_full     <= 1'b0;
      tile_last     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_cur_id <= {1'b0, start_id};
            busy     <= 1'b1;
            // An out-of-range start still finishes the job so the caller sees done.
            if (w_bad_id) begin
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              err     <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          tile_base_id  <= r_cur_id[FEAT_W_P-1:0];
          tile_core_cnt <= w_cores;
          tile_last_len <= w_last_len;
          tile_full     <= (w_cores == c_ncore);
          tile_last     <= w_is_last;
          tile_valid    <= 1'b1;
          r_state       <= S_EMIT;
        end
        S_EMIT: begin
          if (w_hs) begin
            tile_valid <= 1'b0;
            if (tile_last) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur_id <= r_cur_id + c_round;
              r_state  <= S_CALC;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef S2_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_tiles <= '0;
      perf_stall <= '0;
    end else if (w_start_ok) begin
      perf_tiles <= '0;
      perf_stall <= '0;
    end else begin
      if (w_hs && (perf_tiles != 16'hFFFF))
        perf_tiles <= perf_tiles + 16'd1;
      if (tile_valid && !tile_ready && (perf_stall != 16'hFFFF))
        perf_stall <= perf_stall + 16'd1;
    end
  end
`else
  // Perf counters are not built in this configuration.
`endif

endmodule : s2_tile_scheduler

`default_nettype wire

// File: tb/tb_s2_tile_scheduler.sv
// ============================================================================
// Module   : tb_s2_tile_scheduler
// Brief    : Directed, table-driven bench for s2_tile_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_s2_tile_scheduler;

  typedef struct packed {
    logic [11:0] base;
    logic [6:0]  cores;
    logic [5:0]  len;
    logic        full;
    logic        last;
  } tile_t;

  typedef struct {
    logic [11:0] sid;
    logic        bad;
    int          n;
    tile_t       t0;
    tile_t       t1;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] start_id;
  logic        tile_valid;
  logic        tile_ready;
  logic [11:0] tile_base_id;
  logic [6:0]  tile_core_cnt;
  logic [5:0]  tile_last_len;
  logic        tile_full;
  logic        tile_last;
  logic        busy;
  logic        done;
  logic        err;

  logic        start_b;
  logic [11:0] start_id_b;
  logic        tile_valid_b;
  logic        tile_ready_b;
  logic [11:0] tile_base_id_b;
  logic [6:0]  tile_core_cnt_b;
  logic [5:0]  tile_last_len_b;
  logic        tile_full_b;
  logic        tile_last_b;
  logic        busy_b;
  logic        done_b;
  logic        err_b;

`ifdef S2_SCHED_PERF_EN
  logic [15:0] perf_tiles;
  logic [15:0] perf_stall;
  logic [15:0] perf_tiles_b;
  logic [15:0] perf_stall_b;
`endif

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[10];

  s2_tile_scheduler u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_id      (start_id),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .tile_base_id  (tile_base_id),
    .tile_core_cnt (tile_core_cnt),
    .tile_last_len (tile_last_len),
    .tile_full     (tile_full),
    .tile_last     (tile_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
`ifdef S2_SCHED_PERF_EN
    ,
    .perf_tiles    (perf_tiles),
    .perf_stall    (perf_stall)
`endif
  );

  s2_tile_scheduler #(.ALL_FEATURE_P(2048)) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_b),
    .start_id      (start_id_b),
    .tile_valid    (tile_valid_b),
    .tile_ready    (tile_ready_b),
    .tile_base_id  (tile_base_id_b),
    .tile_core_cnt (tile_core_cnt_b),
    .tile_last_len (tile_last_len_b),
    .tile_full     (tile_full_b),
    .tile_last     (tile_last_b),
    .busy          (busy_b),
    .done          (done_b),
    .err           (err_b)
`ifdef S2_SCHED_PERF_EN
    ,
    .perf_tiles    (perf_tiles_b),
    .perf_stall    (perf_stall_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input tile_t e);
    chk({tag, "_valid"}, {31'd0, tile_valid}, 32'd1);
    chk({tag, "_base"},  {20'd0, tile_base_id}, {20'd0, e.base});
    chk({tag, "_cores"}, {25'd0, tile_core_cnt}, {25'd0, e.cores});
    chk({tag, "_len"},   {26'd0, tile_last_len}, {26'd0, e.len});
    chk({tag, "_full"},  {31'd0, tile_full}, {31'd0, e.full});
    chk({tag, "_last"},  {31'd0, tile_last}, {31'd0, e.last});
  endtask

  task automatic run_job(input vec_t v, input string tag);
    tile_t e;
    start_id = v.sid;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    if (v.bad) begin
      chk({tag, "_err_set"},   {31'd0, err}, 32'd1);
      chk({tag, "_done_err"},  {31'd0, done}, 32'd1);
      chk({tag, "_no_valid"},  {31'd0, tile_valid}, 32'd0);
      step();
      chk({tag, "_done_end"},  {31'd0, done}, 32'd0);
      chk({tag, "_busy_end"},  {31'd0, busy}, 32'd0);
      chk({tag, "_err_stick"}, {31'd0, err}, 32'd1);
      chk({tag, "_no_valid2"}, {31'd0, tile_valid}, 32'd0);
    end else begin
      chk({tag, "_err_clear"}, {31'd0, err}, 32'd0);
      step();
      chk({tag, "_latency"}, {31'd0, tile_valid}, 32'd1);
      for (int i = 0; i < v.n; i++) begin
        e = (i == 0) ? v.t0 : v.t1;
        for (int k = 0; k < 6 && !tile_valid; k++) step();
        chk_tile($sformatf("%s_t%0d", tag, i), e);
        tile_ready = 1'b1;
        step();
        tile_ready = 1'b0;
      end
      chk({tag, "_done"},     {31'd0, done}, 32'd1);
      chk({tag, "_valid_lo"}, {31'd0, tile_valid}, 32'd0);
      step();
      chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{sid: 12'd0,    bad: 1'b0, n: 2, t0: '{12'd0,    7'd64, 6'd32, 1'b1, 1'b0},
                                                t1: '{12'd2048, 7'd52, 6'd23, 1'b0, 1'b1}};
    vecs[1] = '{sid: 12'd3700, bad: 1'b0, n: 1, t0: '{12'd3700, 7'd1,  6'd3,  1'b0, 1'b1}, t1: '0};
    vecs[2] = '{sid: 12'd3703, bad: 1'b1, n: 0, t0: '0, t1: '0};
    vecs[3] = '{sid: 12'd1655, bad: 1'b0, n: 1, t0: '{12'd1655, 7'd64, 6'd32, 1'b1, 1'b1}, t1: '0};
    vecs[4] = '{sid: 12'd3671, bad: 1'b0, n: 1, t0: '{12'd3671, 7'd1,  6'd32, 1'b0, 1'b1}, t1: '0};
    vecs[5] = '{sid: 12'd3672, bad: 1'b0, n: 1, t0: '{12'd3672, 7'd1,  6'd31, 1'b0, 1'b1}, t1: '0};
    vecs[6] = '{sid: 12'd1654, bad: 1'b0, n: 2, t0: '{12'd1654, 7'd64, 6'd32, 1'b1, 1'b0},
                                                t1: '{12'd3702, 7'd1,  6'd1,  1'b0, 1'b1}};
    vecs[7] = '{sid: 12'd4095, bad: 1'b1, n: 0, t0: '0, t1: '0};
    vecs[8] = '{sid: 12'd1000, bad: 1'b0, n: 2, t0: '{12'd1000, 7'd64, 6'd32, 1'b1, 1'b0},
                                                t1: '{12'd3048, 7'd21, 6'd15, 1'b0, 1'b1}};
    vecs[9] = '{sid: 12'd3702, bad: 1'b0, n: 1, t0: '{12'd3702, 7'd1,  6'd1,  1'b0, 1'b1}, t1: '0};

    rst_n = 1'b0; start = 1'b0; start_id = '0; tile_ready = 1'b0;
    start_b = 1'b0; start_id_b = '0; tile_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, tile_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_base",  {20'd0, tile_base_id}, 32'd0);
    chk("rst_cores", {25'd0, tile_core_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // Backpressure: fields hold, start is ignored while busy.
    start_id = 12'd0; start = 1'b1; step(); start = 1'b0; step();
    for (int k = 0; k < 5; k++) begin
      start    = (k == 1);
      start_id = 12'd3700;
      chk_tile($sformatf("stall%0d", k), vecs[0].t0);
      step();
    end
    start = 1'b0;
    chk_tile("stall5", vecs[0].t0);
`ifdef S2_SCHED_PERF_EN
    chk("perf_stall", {16'd0, perf_stall}, 32'd5);
`endif
    tile_ready = 1'b1; step(); tile_ready = 1'b0;
    for (int k = 0; k < 6 && !tile_valid; k++) step();
    chk_tile("stall_t1", vecs[0].t1);
    tile_ready = 1'b1; step(); tile_ready = 1'b0;
    chk("stall_done", {31'd0, done}, 32'd1);
    step();
    chk("stall_busy_end", {31'd0, busy}, 32'd0);
`ifdef S2_SCHED_PERF_EN
    chk("perf_tiles",  {16'd0, perf_tiles}, 32'd2);
    chk("perf_stall2", {16'd0, perf_stall}, 32'd5);
`endif

    // Asynchronous reset in the middle of the first tile.
    start_id = 12'd0; start = 1'b1; step(); start = 1'b0; step();
    chk("ar_valid_pre", {31'd0, tile_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, tile_valid}, 32'd0);
    chk("ar_busy",  {31'd0, busy}, 32'd0);
    chk("ar_full",  {31'd0, tile_full}, 32'd0);
    chk("ar_cores", {25'd0, tile_core_cnt}, 32'd0);
    chk("ar_len",   {26'd0, tile_last_len}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run_job(vecs[0], "after_rst");

    // Exact multiple: 2048 features fill one full round with no extra core.
    start_id_b = 12'd0; start_b = 1'b1; step(); start_b = 1'b0; step();
    chk("b_valid", {31'd0, tile_valid_b}, 32'd1);
    chk("b_base",  {20'd0, tile_base_id_b}, 32'd0);
    chk("b_cores", {25'd0, tile_core_cnt_b}, 32'd64);
    chk("b_len",   {26'd0, tile_last_len_b}, 32'd32);
    chk("b_full",  {31'd0, tile_full_b}, 32'd1);
    chk("b_last",  {31'd0, tile_last_b}, 32'd1);
    tile_ready_b = 1'b1; step(); tile_ready_b = 1'b0;
    chk("b_done",  {31'd0, done_b}, 32'd1);
    chk("b_err",   {31'd0, err_b}, 32'd0);
    step();
    chk("b_busy_end", {31'd0, busy_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_s2_tile_scheduler

`default_nettype wire
